pipeline_hazard_sequencer: RTL and testbench
============================================

PIPELINE_HAZARD_SEQUENCER -- requirements
Module: pipeline_hazard_sequencer

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 8'd200: the maximum number of consecutive MEM_WAIT cycles before the error state, legal range 1..255.
REQ-002 SHALL have port CLK, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port RST, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have ports de_rs1 and de_rs2, input, 5 bits each: source register addresses of the instruction in DE.
REQ-005 SHALL have ports de_rs1_used and de_rs2_used, input, 1 bit each: high when DE actually reads rs1 or rs2.
REQ-006 SHALL have port ex_mem_read, input, 1 bit: high when the instruction in EX is a load.
REQ-007 SHALL have port ex_rd, input, 5 bits: destination register of the instruction in EX.
REQ-008 SHALL have port ex_branch_taken, input, 1 bit: high when EX resolves a taken branch or jump.
REQ-009 SHALL have ports mem_req and mem_ready, input, 1 bit each: high when the MEM-stage data access is outstanding, and high when that access completes this cycle.
REQ-010 SHALL have ports pc_write, if_de_write, de_ex_write and ex_mem_write, output, 1 bit each: pipeline register enables.
REQ-011 SHALL have ports if_de_flush and de_ex_flush, output, 1 bit each: insert a bubble (NOP) into the named register.
REQ-012 SHALL have port mem_err, output, 1 bit: sticky indication that the memory timed out.

Function
REQ-013 SHALL implement an FSM with states RUN, MEM_WAIT and ERROR.
REQ-014 In RUN with mem_req=1 and mem_ready=0: SHALL drive all write enables to 0 and both flushes to 0 in the same cycle (Mealy), then go to MEM_WAIT.
REQ-015 In MEM_WAIT: SHALL hold all enables at 0 and ignore ex_branch_taken and load-use.
REQ-016 In MEM_WAIT, on mem_ready=1: SHALL evaluate that cycle exactly as RUN (REQ-017/018) and return to RUN.
REQ-017 Branch flush, in RUN with no memory stall and ex_branch_taken=1: SHALL set pc_write=1, if_de_flush=1, de_ex_flush=1, with all other enables at 1.
REQ-018 Load-use, in RUN with no memory stall, no branch, ex_mem_read=1, ex_rd!=0 and ((de_rs1_used && de_rs1==ex_rd) || (de_rs2_used && de_rs2==ex_rd)): SHALL set pc_write=0, if_de_write=0 and de_ex_flush=1 for exactly one cycle.
REQ-019 Priority SHALL be memory stall > branch flush > load-use; when none is active, all enables=1 and flushes=0.
REQ-020 An 8-bit wait counter SHALL clear on MEM_WAIT entry, increment each MEM_WAIT cycle with mem_ready=0, and saturate at 255.
REQ-021 When the counter reaches MEM_TIMEOUT with mem_ready still 0: SHALL enter ERROR; mem_ready=1 on the same cycle as the limit SHALL take precedence and return to RUN.
REQ-022 ERROR SHALL be terminal until RST: mem_err=1, all enables=0, flushes=0.
REQ-023 An ex_rd of 0 SHALL never raise a load-use stall.

Reset
REQ-024 While RST=1: state=RUN, counter=0, mem_err=0, all enables=1 and both flushes=0.
REQ-025 RST asserted mid-MEM_WAIT or in ERROR SHALL return immediately to RUN.

Configuration
REQ-026 With PIPE_HAZARD_STATS_EN defined: SHALL add outputs stall_cycles[31:0], counting cycles with pc_write=0, and flush_count[31:0], counting branch flushes; both wrapping, and both cleared by RST.
REQ-027 Without PIPE_HAZARD_STATS_EN: those ports and counters SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-028 Package pipe_ctrl_pkg SHALL hold the state enum typedef, the REG_X0 constant (5'd0) and the STAT_W constant (32).
REQ-029 The statistics SHALL live in sub-module pipe_stat_counters, instantiated only under PIPE_HAZARD_STATS_EN.

Verification
REQ-030 Stimulus: ex_mem_read=1, ex_rd=5, de_rs1=5, de_rs1_used=1. Required response: for one cycle pc_write=0, if_de_write=0, de_ex_flush=1; next cycle (ex_mem_read=0) all enables=1.
REQ-031 Stimulus: the REQ-030 load-use condition and ex_branch_taken=1 together. Required response: if_de_flush=1, de_ex_flush=1, pc_write=1.
REQ-032 Stimulus: mem_req=1, mem_ready=0 for 3 cycles, then mem_ready=1. Required response: enables=0 for 3 cycles, 1 on the 4th; state returns to RUN.
REQ-033 Stimulus: MEM_TIMEOUT=4, mem_ready held 0. Required response: ERROR with mem_err=1 after 4 MEM_WAIT cycles, persisting until RST.
REQ-034 Stimulus: ex_rd=0 with a matching rs1 and a load in EX. Required response: no stall.
REQ-035 Stimulus: PIPE_HAZARD_STATS_EN defined, one load-use stall plus one 3-cycle memory wait. Required response: stall_cycles=4.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
// Also provides the per-source load-use match helper.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_t;

    localparam logic [4:0]  REG_X0 = 5'd0;
    localparam int unsigned STAT_W = 32;

    // x0 is hardwired to zero, so a load targeting it never creates a dependency
    function automatic logic src_hazard(input logic       used,
                                        input logic [4:0] rs,
                                        input logic [4:0] rd);
        return used && (rs == rd) && (rd != REG_X0);
    endfunction

endpackage

// File: rtl/pipe_stat_counters.sv
// Wrapping stall-cycle and branch-flush counters for the hazard sequencer.
// Only instantiated when PIPE_HAZARD_STATS_EN is defined.
module pipe_stat_counters
    import pipe_ctrl_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              stall,
    input  logic              flush,
    output logic [STAT_W-1:0] stall_cycles,
    output logic [STAT_W-1:0] flush_count
);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (stall) begin
                stall_cycles <= stall_cycles + STAT_W'(1);
            end
            if (flush) begin
                flush_count <= flush_count + STAT_W'(1);
            end
        end
    end

endmodule

// File: rtl/pipeline_hazard_sequencer.sv
// Pipeline stall/flush control: memory stall > branch flush > load-use, with memory timeout.
// Optional statistics outputs are enabled by defining PIPE_HAZARD_STATS_EN.
module pipeline_hazard_sequencer
    import pipe_ctrl_pkg::*;
#(
    parameter logic [7:0] MEM_TIMEOUT = 8'd200
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [4:0]        de_rs1,
    input  logic [4:0]        de_rs2,
    input  logic              de_rs1_used,
    input  logic              de_rs2_used,
    input  logic              ex_mem_read,
    input  logic [4:0]        ex_rd,
    input  logic              ex_branch_taken,
    input  logic              mem_req,
    input  logic              mem_ready,
    output logic              pc_write,
    output logic              if_de_write,
    output logic              de_ex_write,
    output logic              ex_mem_write,
    output logic              if_de_flush,
    output logic              de_ex_flush,
    output logic              mem_err
`ifdef PIPE_HAZARD_STATS_EN
    ,
    output logic [STAT_W-1:0] stall_cycles,
    output logic [STAT_W-1:0] flush_count
`endif
);

    state_t     state, state_next;
    logic [7:0] wait_cnt, wait_cnt_next, wait_inc;
    logic       load_use;
    logic       run_eval;
    logic       hold;

    assign wait_inc = (wait_cnt == 8'hFF) ? wait_cnt : wait_cnt + 8'd1;
    assign load_use = ex_mem_read &&
                      (src_hazard(de_rs1_used, de_rs1, ex_rd) ||
                       src_hazard(de_rs2_used, de_rs2, ex_rd));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
        end
    end

    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        run_eval      = 1'b0;
        hold          = 1'b0;
        pc_write      = 1'b1;
        if_de_write   = 1'b1;
        de_ex_write   = 1'b1;
        ex_mem_write  = 1'b1;
        if_de_flush   = 1'b0;
        de_ex_flush   = 1'b0;
        mem_err       = 1'b0;

        case (state)
            RUN: begin
                if (mem_req && !mem_ready) begin
                    hold          = 1'b1;
                    state_next    = MEM_WAIT;
                    wait_cnt_next = '0;
                end else begin
                    run_eval = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    run_eval   = 1'b1;
                    state_next = RUN;
                end else begin
                    hold          = 1'b1;
                    wait_cnt_next = wait_inc;
                    if (wait_inc >= MEM_TIMEOUT) begin
                        state_next = ERROR;
                    end
                end
            end
            ERROR: begin
                hold    = 1'b1;
                mem_err = 1'b1;
            end
            default: state_next = RUN;
        endcase

        // The completing MEM_WAIT cycle shares the RUN hazard resolution
        if (run_eval) begin
            if (ex_branch_taken) begin
                if_de_flush = 1'b1;
                de_ex_flush = 1'b1;
            end else if (load_use) begin
                pc_write    = 1'b0;
                if_de_write = 1'b0;
                de_ex_flush = 1'b1;
            end
        end

        if (hold) begin
            pc_write     = 1'b0;
            if_de_write  = 1'b0;
            de_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
        end

        // Reset forces free-running outputs regardless of a pending memory request
        if (RST) begin
            pc_write     = 1'b1;
            if_de_write  = 1'b1;
            de_ex_write  = 1'b1;
            ex_mem_write = 1'b1;
            if_de_flush  = 1'b0;
            de_ex_flush  = 1'b0;
            mem_err      = 1'b0;
        end
    end

`ifdef PIPE_HAZARD_STATS_EN
    pipe_stat_counters u_stats (
        .CLK          (CLK),
        .RST          (RST),
        .stall        (~pc_write),
        .flush        (if_de_flush),
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
    );
`endif

endmodule

// File: tb/tb_pipeline_hazard_sequencer.sv
// Self-checking bench for pipeline_hazard_sequencer: directed scenarios plus
// randomized traffic against a rule-level reference model.
module tb_pipeline_hazard_sequencer;

    localparam logic [7:0] TIMEOUT = 8'd4;

    localparam logic [6:0] OUT_RUN     = 7'b1111000;
    localparam logic [6:0] OUT_STALL   = 7'b0000000;
    localparam logic [6:0] OUT_BRANCH  = 7'b1111110;
    localparam logic [6:0] OUT_LOADUSE = 7'b0011010;
    localparam logic [6:0] OUT_ERR     = 7'b0000001;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [4:0] de_rs1 = '0, de_rs2 = '0, ex_rd = '0;
    logic       de_rs1_used = 1'b0, de_rs2_used = 1'b0;
    logic       ex_mem_read = 1'b0, ex_branch_taken = 1'b0;
    logic       mem_req = 1'b0, mem_ready = 1'b0;
    logic       pc_write, if_de_write, de_ex_write, ex_mem_write;
    logic       if_de_flush, de_ex_flush, mem_err;
`ifdef PIPE_HAZARD_STATS_EN
    logic [31:0] stall_cycles, flush_count;
`endif

    logic [6:0] obs;
    assign obs = {pc_write, if_de_write, de_ex_write, ex_mem_write,
                  if_de_flush, de_ex_flush, mem_err};

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: waiting on memory, cycles waited, timed out
    bit m_wait, m_dead;
    int m_waited;
    int m_stalls, m_flushes;

    pipeline_hazard_sequencer #(.MEM_TIMEOUT(TIMEOUT)) dut (
        .CLK             (CLK),
        .RST             (RST),
        .de_rs1          (de_rs1),
        .de_rs2          (de_rs2),
        .de_rs1_used     (de_rs1_used),
        .de_rs2_used     (de_rs2_used),
        .ex_mem_read     (ex_mem_read),
        .ex_rd           (ex_rd),
        .ex_branch_taken (ex_branch_taken),
        .mem_req         (mem_req),
        .mem_ready       (mem_ready),
        .pc_write        (pc_write),
        .if_de_write     (if_de_write),
        .de_ex_write     (de_ex_write),
        .ex_mem_write    (ex_mem_write),
        .if_de_flush     (if_de_flush),
        .de_ex_flush     (de_ex_flush),
        .mem_err         (mem_err)
`ifdef PIPE_HAZARD_STATS_EN
        ,
        .stall_cycles    (stall_cycles),
        .flush_count     (flush_count)
`endif
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got running required finished");
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] expected();
        logic lu;
        if (RST) return OUT_RUN;
        if (m_dead) return OUT_ERR;
        if (!mem_ready && (m_wait || mem_req)) return OUT_STALL;
        if (ex_branch_taken) return OUT_BRANCH;
        lu = ex_mem_read && (ex_rd != 5'd0) &&
             ((de_rs1_used && de_rs1 == ex_rd) || (de_rs2_used && de_rs2 == ex_rd));
        return lu ? OUT_LOADUSE : OUT_RUN;
    endfunction

    task automatic model_reset();
        m_wait    = 0;
        m_dead    = 0;
        m_waited  = 0;
        m_stalls  = 0;
        m_flushes = 0;
    endtask

    task automatic model_edge();
        logic [6:0] e;
        if (RST) begin
            model_reset();
            return;
        end
        e = expected();
        if (!e[6]) m_stalls++;
        if (e[2]) m_flushes++;
        if (m_dead) begin
        end else if (!m_wait && mem_req && !mem_ready) begin
            m_wait   = 1;
            m_waited = 0;
        end else if (m_wait && !mem_ready) begin
            m_waited++;
            if (m_waited >= int'(TIMEOUT)) m_dead = 1;
        end else begin
            m_wait = 0;
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        model_edge();
        #1;
    endtask

    task automatic set_idle();
        de_rs1 = '0; de_rs2 = '0; ex_rd = '0;
        de_rs1_used = 0; de_rs2_used = 0;
        ex_mem_read = 0; ex_branch_taken = 0;
        mem_req = 0; mem_ready = 0;
    endtask

    task automatic pulse_reset();
        RST = 1;
        model_reset();
        tick();
        RST = 0;
    endtask

    task automatic test_reset();
        RST = 1;
        model_reset();
        mem_req = 1; mem_ready = 0; ex_branch_taken = 1;
        #2;
        n_checks++;
        if (obs !== OUT_RUN) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b required %b", obs, OUT_RUN);
        end
        tick();
        n_checks++;
        if (obs !== OUT_RUN) begin
            n_fail++;
            $display("FAIL reset_held: got %b required %b", obs, OUT_RUN);
        end
        RST = 0;
        set_idle();
        @(negedge CLK);
        n_checks++;
        if (obs !== OUT_RUN) begin
            n_fail++;
            $display("FAIL post_reset_idle: got %b required %b", obs, OUT_RUN);
        end
        tick();
    endtask

    typedef struct {
        logic [4:0] rs1, rs2, rd;
        logic       u1, u2, ld;
        logic [6:0] exp;
    } lu_case_t;

    task automatic test_load_use();
        lu_case_t tbl[7];
        tbl[0] = '{5'd5, 5'd0, 5'd5, 1, 0, 1, OUT_LOADUSE};
        tbl[1] = '{5'd0, 5'd5, 5'd5, 1, 0, 0, OUT_RUN};
        tbl[2] = '{5'd3, 5'd7, 5'd7, 1, 1, 1, OUT_LOADUSE};
        tbl[3] = '{5'd9, 5'd2, 5'd9, 0, 1, 1, OUT_RUN};
        tbl[4] = '{5'd8, 5'd8, 5'd8, 0, 0, 1, OUT_RUN};
        tbl[5] = '{5'd1, 5'd4, 5'd6, 1, 1, 1, OUT_RUN};
        tbl[6] = '{5'd31, 5'd0, 5'd31, 1, 1, 1, OUT_LOADUSE};
        for (int i = 0; i < 7; i++) begin
            set_idle();
            de_rs1 = tbl[i].rs1; de_rs2 = tbl[i].rs2; ex_rd = tbl[i].rd;
            de_rs1_used = tbl[i].u1; de_rs2_used = tbl[i].u2; ex_mem_read = tbl[i].ld;
            @(negedge CLK);
            n_checks++;
            if (obs !== tbl[i].exp) begin
                n_fail++;
                $display("FAIL load_use_case%0d: got %b required %b", i, obs, tbl[i].exp);
            end
            tick();
            if (i == 0) begin
                ex_mem_read = 0;
                @(negedge CLK);
                n_checks++;
                if (obs !== OUT_RUN) begin
                    n_fail++;
                    $display("FAIL load_use_release: got %b required %b", obs, OUT_RUN);
                end
                tick();
            end
        end
        set_idle();
    endtask

    task automatic test_x0();
        set_idle();
        ex_mem_read = 1; ex_rd = 5'd0;
        de_rs1 = 5'd0; de_rs1_used = 1; de_rs2 = 5'd0; de_rs2_used = 1;
        @(negedge CLK);
        n_checks++;
        if (obs !== OUT_RUN) begin
            n_fail++;
            $display("FAIL x0_no_stall: got %b required %b", obs, OUT_RUN);
        end
        tick();
        set_idle();
    endtask

    task automatic test_branch_priority();
        set_idle();
        ex_mem_read = 1; ex_rd = 5'd5; de_rs1 = 5'd5; de_rs1_used = 1; ex_branch_taken = 1;
        @(negedge CLK);
        n_checks++;
        if (obs !== OUT_BRANCH) begin
            n_fail++;
            $display("FAIL branch_over_load_use: got %b required %b", obs, OUT_BRANCH);
        end
        tick();
        mem_req = 1; mem_ready = 0;
        @(negedge CLK);
        n_checks++;
        if (obs !== OUT_STALL) begin
            n_fail++;
            $display("FAIL mem_over_branch: got %b required %b", obs, OUT_STALL);
        end
        tick();
        mem_ready = 1;
        @(negedge CLK);
        n_checks++;
        if (obs !== OUT_BRANCH) begin
            n_fail++;
            $display("FAIL branch_on_mem_ready: got %b required %b", obs, OUT_BRANCH);
        end
        tick();
        set_idle();
    endtask

    task automatic test_mem_wait();
        logic [6:0] exp;
        set_idle();
        for (int c = 0; c < 4; c++) begin
            mem_req = 1;
            mem_ready = (c == 3);
            if (c == 1) begin
                ex_mem_read = 1; ex_rd = 5'd4; de_rs2 = 5'd4; de_rs2_used = 1; ex_branch_taken = 1;
            end
            if (c == 3) begin
                ex_mem_read = 0; ex_branch_taken = 0;
            end
            exp = (c == 3) ? OUT_RUN : OUT_STALL;
            @(negedge CLK);
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL mem_wait_cycle%0d: got %b required %b", c, obs, exp);
            end
            tick();
        end
        set_idle();
        @(negedge CLK);
        n_checks++;
        if (obs !== OUT_RUN) begin
            n_fail++;
            $display("FAIL mem_wait_back_to_run: got %b required %b", obs, OUT_RUN);
        end
        tick();
    endtask

    task automatic test_timeout();
        set_idle();
        mem_req = 1; mem_ready = 0;
        for (int c = 0; c <= int'(TIMEOUT); c++) begin
            @(negedge CLK);
            n_checks++;
            if (obs !== OUT_STALL) begin
                n_fail++;
                $display("FAIL timeout_wait%0d: got %b required %b", c, obs, OUT_STALL);
            end
            tick();
        end
        for (int c = 0; c < 3; c++) begin
            mem_ready = (c != 0);
            ex_branch_taken = (c == 2);
            @(negedge CLK);
            n_checks++;
            if (obs !== OUT_ERR) begin
                n_fail++;
                $display("FAIL error_sticky%0d: got %b required %b", c, obs, OUT_ERR);
            end
            tick();
        end
        RST = 1;
        model_reset();
        #2;
        n_checks++;
        if (obs !== OUT_RUN) begin
            n_fail++;
            $display("FAIL reset_from_error: got %b required %b", obs, OUT_RUN);
        end
        RST = 0;
        set_idle();
        @(negedge CLK);
        n_checks++;
        if (obs !== OUT_RUN) begin
            n_fail++;
            $display("FAIL run_after_error_reset: got %b required %b", obs, OUT_RUN);
        end
        tick();
    endtask

    task automatic test_timeout_boundary();
        logic [6:0] exp;
        set_idle();
        mem_req = 1;
        for (int c = 0; c <= int'(TIMEOUT); c++) begin
            mem_ready = (c == int'(TIMEOUT));
            exp = (c == int'(TIMEOUT)) ? OUT_RUN : OUT_STALL;
            @(negedge CLK);
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL ready_at_limit%0d: got %b required %b", c, obs, exp);
            end
            tick();
        end
        set_idle();
        @(negedge CLK);
        n_checks++;
        if (obs !== OUT_RUN) begin
            n_fail++;
            $display("FAIL no_error_after_limit_ready: got %b required %b", obs, OUT_RUN);
        end
        tick();
        mem_req = 1; mem_ready = 0;
        tick();
        tick();
        RST = 1;
        model_reset();
        #2;
        RST = 0;
        set_idle();
        @(negedge CLK);
        n_checks++;
        if (obs !== OUT_RUN) begin
            n_fail++;
            $display("FAIL reset_mid_wait: got %b required %b", obs, OUT_RUN);
        end
        tick();
    endtask

    task automatic test_random();
        logic [6:0] exp;
        pulse_reset();
        for (int n = 0; n < 400; n++) begin
            RST = 0;
            if (m_dead && $urandom_range(0, 2) == 0) begin
                RST = 1;
                model_reset();
            end
            de_rs1 = 5'($urandom_range(0, 3));
            de_rs2 = 5'($urandom_range(0, 3));
            ex_rd  = 5'($urandom_range(0, 3));
            de_rs1_used = $urandom_range(0, 1) == 1;
            de_rs2_used = $urandom_range(0, 1) == 1;
            ex_mem_read = $urandom_range(0, 1) == 1;
            ex_branch_taken = $urandom_range(0, 4) == 0;
            mem_req   = $urandom_range(0, 3) == 0;
            mem_ready = $urandom_range(0, 1) == 1;
            exp = expected();
            @(negedge CLK);
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL random_cycle%0d: got %b required %b", n, obs, exp);
            end
            tick();
        end
        RST = 0;
        set_idle();
`ifdef PIPE_HAZARD_STATS_EN
        @(negedge CLK);
        n_checks++;
        if (stall_cycles !== 32'(m_stalls) || flush_count !== 32'(m_flushes)) begin
            n_fail++;
            $display("FAIL random_stats: got %0d/%0d required %0d/%0d",
                     stall_cycles, flush_count, m_stalls, m_flushes);
        end
`endif
        pulse_reset();
    endtask

`ifdef PIPE_HAZARD_STATS_EN
    task automatic test_stats();
        pulse_reset();
        set_idle();
        ex_mem_read = 1; ex_rd = 5'd5; de_rs1 = 5'd5; de_rs1_used = 1;
        tick();
        set_idle();
        mem_req = 1;
        tick(); tick(); tick();
        mem_ready = 1;
        tick();
        set_idle();
        @(negedge CLK);
        n_checks++;
        if (stall_cycles !== 32'd4 || flush_count !== 32'd0) begin
            n_fail++;
            $display("FAIL stats_stalls: got %0d/%0d required 4/0", stall_cycles, flush_count);
        end
        tick();
        ex_branch_taken = 1;
        tick();
        set_idle();
        @(negedge CLK);
        n_checks++;
        if (stall_cycles !== 32'd4 || flush_count !== 32'd1) begin
            n_fail++;
            $display("FAIL stats_flush: got %0d/%0d required 4/1", stall_cycles, flush_count);
        end
        tick();
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_load_use();
        test_x0();
        test_branch_priority();
        test_mem_wait();
        test_timeout();
        test_timeout_boundary();
`ifdef PIPE_HAZARD_STATS_EN
        test_stats();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
